// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the multiplexed 3-digit BCD display scanner.
package bcd_disp_pkg;

  localparam int DIGITS = 3;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Segment order is {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment glyph decoder; non-decimal nibbles render as a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan_ctrl.sv
// Time-multiplexed scan controller: per-frame snapshot, blank/show sequencing,
// leading-zero blanking and output polarity for a shared 7-segment bus.
module bcd_display_scan_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [11:0]       bcd_in,
  input  logic              lz_blank,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_start
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [DIGITS-1:0]  DIG_ONE    = DIGITS'(1);
  localparam logic [6:0]         SEG_POL    = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]  DIG_POL    = {DIGITS{ACTIVE_LOW}};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [11:0]         snap_q, snap_d;
  logic                snap_lz_q, snap_lz_d;
  logic                frame_start_q, frame_start_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic [3:0]          nibble;
  logic                lz_hide;
  logic [6:0]          dec_seg;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    snap_d        = snap_q;
    snap_lz_d     = snap_lz_q;
    frame_start_d = 1'b0;
    if (ena) begin
      case (state_q)
        BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = SHOW;
            timer_d = '0;
            if (idx_q == '0) begin
              snap_d        = bcd_in;
              snap_lz_d     = lz_blank;
              frame_start_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        SHOW: begin
          if (timer_q == DWELL_LAST) begin
            state_d = BLANK;
            timer_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        default: begin
          state_d = BLANK;
          timer_d = '0;
        end
      endcase
    end
  end

  // Glyph is chosen from next-state values so outputs line up with the state register.
  always_comb begin
    nibble  = snap_d[3:0];
    lz_hide = 1'b0;
    if (idx_d == '0) begin
      nibble = snap_d[3:0];
    end else if (idx_d == IDX_ONE) begin
      nibble  = snap_d[7:4];
      lz_hide = snap_lz_d && (snap_d[11:8] == 4'h0) && (snap_d[7:4] == 4'h0);
    end else begin
      nibble  = snap_d[11:8];
      lz_hide = snap_lz_d && (snap_d[11:8] == 4'h0);
    end
  end

  bcd_to_7seg u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d     = seg_q;
    dig_sel_d = dig_sel_q;
    if (ena) begin
      if (state_d == SHOW) begin
        dig_sel_d = (DIG_ONE << idx_d) ^ DIG_POL;
        seg_d     = (lz_hide ? SEG_OFF : dec_seg) ^ SEG_POL;
      end else begin
        dig_sel_d = DIG_POL;
        seg_d     = SEG_OFF ^ SEG_POL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      timer_q       <= '0;
      snap_q        <= '0;
      snap_lz_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF ^ SEG_POL;
      dig_sel_q     <= DIG_POL;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      snap_q        <= snap_d;
      snap_lz_q     <= snap_lz_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Self-checking bench for bcd_display_scan_ctrl: vector table feeding a frame scoreboard,
// plus directed timing, ena-hold and mid-operation reset sequences on both polarities.
module tb_bcd_display_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 3 * (DWELL + BLANK);
  localparam int NVEC  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [11:0] bcd_in;
  logic        lz_blank;
  logic [6:0]  seg, seg_al;
  logic [2:0]  dig_sel, dig_sel_al;
  logic        fs, fs_al;

  always #5 clk = ~clk;

  bcd_display_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b0)) u_dut (
    .clk (clk), .rst_n (rst_n), .ena (ena), .bcd_in (bcd_in), .lz_blank (lz_blank),
    .seg (seg), .dig_sel (dig_sel), .frame_start (fs)
  );

  bcd_display_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk (clk), .rst_n (rst_n), .ena (ena), .bcd_in (bcd_in), .lz_blank (lz_blank),
    .seg (seg_al), .dig_sel (dig_sel_al), .frame_start (fs_al)
  );

  typedef struct {
    logic [11:0] bcd;
    logic        lz;
    int          mid_wait;
    logic [6:0]  g0;
    logic [6:0]  g1;
    logic [6:0]  g2;
  } vec_t;

  typedef struct {
    logic [2:0] dig;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_en    = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One negedge sample; when enabled, every lit cycle is matched against the scoreboard.
  task automatic tick();
    exp_t       e;
    logic [2:0] inv_dig;
    logic [6:0] inv_seg;
    @(negedge clk);
    if (sb_en) begin
      if (dig_sel != 3'b000) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_dig_sel", dig_sel, 0);
        end else begin
          e       = sb_q.pop_front();
          inv_dig = ~e.dig;
          inv_seg = ~e.seg;
          checkOutput("sb_dig_sel", dig_sel, e.dig);
          checkOutput("sb_seg", seg, e.seg);
          checkOutput("sb_frame_start", fs, e.fs);
          checkOutput("sb_al_dig_sel", dig_sel_al, inv_dig);
          checkOutput("sb_al_seg", seg_al, inv_seg);
          checkOutput("sb_al_frame_start", fs_al, e.fs);
        end
      end else begin
        checkOutput("blank_seg", seg, 0);
        checkOutput("blank_frame_start", fs, 0);
        checkOutput("blank_al_seg", seg_al, 7'h7F);
        checkOutput("blank_al_dig_sel", dig_sel_al, 3'b111);
      end
    end
  endtask

  task automatic pushFrame(input vec_t v);
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < DWELL; k++) begin
        e.dig = 3'b001 << d;
        e.seg = (d == 0) ? v.g0 : (d == 1) ? v.g1 : v.g2;
        e.fs  = (d == 0) && (k == 0);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic waitFrameStart(input int bound, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!fs && cnt < bound);
    if (!fs) checkOutput("frame_start_timeout", fs, 1);
  endtask

  // Called on the negedge of a frame_start cycle; the frame after this one shows v.
  task automatic applyStimulus(input vec_t v);
    int cnt;
    repeat (v.mid_wait) tick();
    bcd_in   = v.bcd;
    lz_blank = v.lz;
    pushFrame(v);
    waitFrameStart(FRAME + 4, cnt);
    checkOutput("vec_frame_period", cnt, FRAME - v.mid_wait);
  endtask

  initial begin
    vec_t v123;
    int   cnt;
    int   c;

    v123     = '{12'h123, 1'b0, 0, 7'h4F, 7'h5B, 7'h06};
    vecs[0]  = '{12'h456, 1'b0, 7, 7'h7D, 7'h6D, 7'h66};
    vecs[1]  = '{12'h007, 1'b1, 0, 7'h07, 7'h00, 7'h00};
    vecs[2]  = '{12'h000, 1'b1, 0, 7'h3F, 7'h00, 7'h00};
    vecs[3]  = '{12'h050, 1'b1, 0, 7'h3F, 7'h6D, 7'h00};
    vecs[4]  = '{12'h007, 1'b0, 0, 7'h07, 7'h3F, 7'h3F};
    vecs[5]  = '{12'hA9F, 1'b0, 0, 7'h40, 7'h6F, 7'h40};
    vecs[6]  = '{12'h0A0, 1'b1, 0, 7'h3F, 7'h40, 7'h00};
    vecs[7]  = '{12'h890, 1'b1, 0, 7'h3F, 7'h6F, 7'h7F};
    vecs[8]  = '{12'hF00, 1'b1, 0, 7'h3F, 7'h3F, 7'h40};
    vecs[9]  = '{12'h100, 1'b1, 0, 7'h3F, 7'h3F, 7'h06};
    vecs[10] = '{12'h000, 1'b0, 0, 7'h3F, 7'h3F, 7'h3F};
    vecs[11] = '{12'h123, 1'b0, 0, 7'h4F, 7'h5B, 7'h06};

    rst_n    = 1'b0;
    ena      = 1'b1;
    bcd_in   = 12'h123;
    lz_blank = 1'b0;
    repeat (3) tick();
    checkOutput("reset_seg", seg, 0);
    checkOutput("reset_dig_sel", dig_sel, 0);
    checkOutput("reset_frame_start", fs, 0);
    checkOutput("reset_al_seg", seg_al, 7'h7F);
    checkOutput("reset_al_dig_sel", dig_sel_al, 3'b111);

    pushFrame(v123);
    pushFrame(v123);
    sb_en = 1'b1;
    rst_n = 1'b1;
    waitFrameStart(10, cnt);
    checkOutput("first_frame_start_edges", cnt, BLANK);
    waitFrameStart(FRAME + 4, cnt);
    checkOutput("frame_period", cnt, FRAME);

    // Snapshot change mid-frame, LZ blanking and invalid nibbles all flow through the scoreboard.
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

    repeat (FRAME - 1) tick();
    checkOutput("sb_drained", sb_q.size(), 0);
    sb_en = 1'b0;
    waitFrameStart(FRAME + 4, cnt);

    c = 0;
    repeat (7) begin tick(); c++; end
    checkOutput("hold_pre_dig_sel", dig_sel, 3'b010);
    ena = 1'b0;
    repeat (10) begin
      tick();
      c++;
      checkOutput("hold_dig_sel", dig_sel, 3'b010);
      checkOutput("hold_seg", seg, vecs[NVEC-1].g1);
    end
    ena = 1'b1;
    repeat (2) begin
      tick();
      c++;
      checkOutput("hold_resume_dig_sel", dig_sel, 3'b010);
    end
    tick();
    c++;
    checkOutput("hold_resume_blank", dig_sel, 3'b000);
    waitFrameStart(FRAME + 20, cnt);
    checkOutput("hold_frame_period", c + cnt, FRAME + 10);

    ena = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("hold_fs_cleared", fs, 0);
      checkOutput("hold_fs_dig_sel", dig_sel, 3'b001);
      checkOutput("hold_fs_seg", seg, vecs[NVEC-1].g0);
    end
    ena = 1'b1;
    waitFrameStart(FRAME + 4, cnt);
    checkOutput("hold_fs_frame_period", cnt + 2, FRAME + 2);

    repeat (13) tick();
    checkOutput("midreset_pre_dig_sel", dig_sel, 3'b100);
    rst_n = 1'b0;
    tick();
    checkOutput("midreset_seg", seg, 0);
    checkOutput("midreset_dig_sel", dig_sel, 0);
    checkOutput("midreset_al_seg", seg_al, 7'h7F);
    checkOutput("midreset_al_dig_sel", dig_sel_al, 3'b111);
    rst_n = 1'b1;
    waitFrameStart(10, cnt);
    checkOutput("midreset_frame_start_edges", cnt, BLANK);
    checkOutput("restart_dig_sel", dig_sel, 3'b001);
    checkOutput("restart_seg", seg, 7'h4F);
    checkOutput("restart_al_dig_sel", dig_sel_al, 3'b110);
    checkOutput("restart_al_seg", seg_al, 7'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
